// File: rtl/catcore_fetch_pkg.sv
// Shared fetch-side definitions: FSM state encoding and default bus widths.
package catcore_fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_RESP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_output_register.sv
// One-entry valid/ready holding register presenting a fetched word and its PC to the decoder.
module fetch_output_register
  import catcore_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  consume_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // A load wins over a same-cycle consume, so capture+consume keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM: requests the word at the current PC, holds the PC until the word returns,
// and discards in-flight responses across a control-flow flush.
module instruction_fetch_unit
  import catcore_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_address,
  output logic                  pc_halt,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready
);

  fetch_state_t          state_q, state_d;
  logic                  drop_q, drop_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  slot_free;
  logic                  handshake;
  logic                  accept;

  assign slot_free = !inst_valid || inst_ready;
  assign handshake = mem_req_valid && mem_req_ready;
  assign accept    = !reset && (state_q == WAIT_RESP) && mem_resp_valid && !drop_q && !flush;

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    req_pc_d      = req_pc_q;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    pc_halt       = 1'b1;
    // Reset is synchronous, so the combinational outputs are gated explicitly while it is held.
    if (!reset) begin
      pc_halt = !(accept || flush);
      unique case (state_q)
        IDLE: state_d = REQUEST;
        REQUEST: begin
          mem_req_valid = slot_free;
          mem_req_addr  = pc_address;
          req_pc_d      = pc_address;
          if (slot_free && mem_req_ready) begin
            state_d = WAIT_RESP;
            drop_d  = flush;
          end
        end
        WAIT_RESP: begin
          if (mem_resp_valid) begin
            state_d = REQUEST;
            drop_d  = 1'b0;
          end else if (flush) begin
            drop_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_output_register #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_output_register (
    .clock    (clock),
    .reset    (reset),
    .load_i   (accept),
    .consume_i(inst_ready),
    .clear_i  (flush),
    .data_i   (mem_resp_data),
    .pc_i     (req_pc_q),
    .valid_o  (inst_valid),
    .data_o   (inst_data),
    .pc_o     (inst_pc)
  );

  logic unused_handshake;
  assign unused_handshake = handshake;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small PC model closing the halt loop.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic        pc_halt;
  logic        flush;
  logic [31:0] flush_target;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int unsigned checks = 0;
  int unsigned failures = 0;

  instruction_fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pc_address    (pc_address),
    .pc_halt       (pc_halt),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  always #5 clock = ~clock;

  // Environment PC register: loads target on flush, advances by 4 when not halted.
  always @(posedge clock) begin
    if (reset)         pc_address <= 32'h0;
    else if (flush)    pc_address <= flush_target;
    else if (!pc_halt) pc_address <= pc_address + 32'd4;
  end

  task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    flush_target   = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    inst_ready     = 1'b1;

    // Reset held for three cycles
    tick(); tick(); tick();
    check_value("rst_inst_valid", inst_valid, 0);
    check_value("rst_inst_data", inst_data, 0);
    check_value("rst_inst_pc", inst_pc, 0);
    check_value("rst_req_valid", mem_req_valid, 0);
    check_value("rst_req_addr", mem_req_addr, 0);
    check_value("rst_pc_halt", pc_halt, 1);

    reset = 1'b0;
    #1;
    check_value("idle_req_valid", mem_req_valid, 0);
    check_value("idle_pc_halt", pc_halt, 1);
    tick();
    check_value("first_req_valid", mem_req_valid, 1);
    check_value("first_req_addr", mem_req_addr, 32'h0);
    check_value("first_pc_halt", pc_halt, 1);

    // First fetch with a 1-cycle response
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    check_value("wait_req_valid", mem_req_valid, 0);
    check_value("wait_pc_halt", pc_halt, 1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h00A00093;
    #1;
    check_value("resp_pc_halt", pc_halt, 0);
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    #1;
    check_value("cap_inst_valid", inst_valid, 1);
    check_value("cap_inst_data", inst_data, 32'h00A00093);
    check_value("cap_inst_pc", inst_pc, 32'h0);
    check_value("cap_pc_advanced", pc_address, 32'h4);
    check_value("cap_next_req_valid", mem_req_valid, 1);
    check_value("cap_next_req_addr", mem_req_addr, 32'h4);
    check_value("cap_pc_halt", pc_halt, 1);

    // Decoder stall: no request while the slot is occupied
    inst_ready    = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check_value("stall_req_valid", mem_req_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_value("stall_req_valid_loop", mem_req_valid, 0);
      check_value("stall_inst_data", inst_data, 32'h00A00093);
      check_value("stall_inst_valid", inst_valid, 1);
    end
    inst_ready = 1'b1;
    #1;
    check_value("unstall_req_valid", mem_req_valid, 1);
    check_value("unstall_req_addr", mem_req_addr, 32'h4);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check_value("consumed_inst_valid", inst_valid, 0);
    check_value("consumed_req_valid", mem_req_valid, 0);

    // Flush while waiting: response two cycles later is dropped
    flush        = 1'b1;
    flush_target = 32'h40;
    #1;
    check_value("flush_pc_halt", pc_halt, 0);
    tick();
    flush = 1'b0;
    #1;
    check_value("flush_pc_loaded", pc_address, 32'h40);
    check_value("flush_inst_valid", inst_valid, 0);
    check_value("flush_req_valid", mem_req_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    #1;
    check_value("drop_pc_halt", pc_halt, 1);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check_value("drop_inst_valid", inst_valid, 0);
    check_value("drop_pc_held", pc_address, 32'h40);
    check_value("drop_req_valid", mem_req_valid, 1);
    check_value("drop_req_addr", mem_req_addr, 32'h40);

    // Memory not ready for 4 cycles, spurious response in REQUEST
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = (i == 1);
      mem_resp_data  = 32'h12345678;
      #1;
      check_value("notready_req_valid", mem_req_valid, 1);
      check_value("notready_pc_halt", pc_halt, 1);
      tick();
      check_value("notready_inst_valid", inst_valid, 0);
    end
    mem_resp_valid = 1'b0;
    check_value("notready_pc_held", pc_address, 32'h40);
    mem_req_ready = 1'b1;
    #1;
    check_value("ready_req_addr", mem_req_addr, 32'h40);
    tick();
    mem_req_ready = 1'b0;
    #1;
    check_value("accepted_req_valid", mem_req_valid, 0);
    tick();
    check_value("k2_inst_valid", inst_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h11111111;
    #1;
    check_value("k2_pc_halt", pc_halt, 0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check_value("k2_cap_valid", inst_valid, 1);
    check_value("k2_cap_data", inst_data, 32'h11111111);
    check_value("k2_cap_pc", inst_pc, 32'h40);
    check_value("k2_pc_advanced", pc_address, 32'h44);

    // Reset during WAIT_RESP with the response arriving inside reset
    mem_req_ready = 1'b1;
    #1;
    check_value("pre_rst_req_addr", mem_req_addr, 32'h44);
    tick();
    mem_req_ready  = 1'b0;
    reset          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hCAFEF00D;
    #1;
    check_value("midrst_pc_halt", pc_halt, 1);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check_value("midrst_inst_valid", inst_valid, 0);
    check_value("midrst_inst_data", inst_data, 32'h0);
    check_value("midrst_req_valid", mem_req_valid, 0);
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    check_value("post_rst_idle_req", mem_req_valid, 0);
    check_value("post_rst_pc_halt", pc_halt, 1);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check_value("post_rst_inst_valid", inst_valid, 0);
    check_value("post_rst_req_valid", mem_req_valid, 1);
    check_value("post_rst_req_addr", mem_req_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch-side counterpart of the program counter. It takes the current PC address, issues a request to instruction memory over a valid/ready interface, and presents the returned word to the decoder with a valid/ready handshake. It drives the PC's `halt` input so the PC advances exactly once per completed fetch, and it discards in-flight fetches on a control-flow flush.

## Interface
- ADDR_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction word width
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- pc_address  in  ADDR_WIDTH  current PC value (PC register output)
- pc_halt  out  1  PC hold; high freezes the PC, low lets it load its next address at the next edge
- flush  in  1  branch/jump taken this cycle; PC loads target at next edge
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  ADDR_WIDTH  fetch address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  read data valid (one pulse per accepted request)
- mem_resp_data  in  DATA_WIDTH  read data
- inst_valid  out  1  instruction available to decoder
- inst_data  out  DATA_WIDTH  fetched instruction
- inst_pc  out  ADDR_WIDTH  address the instruction was fetched from
- inst_ready  in  1  decoder consumes instruction

## Operation
- States: IDLE, REQUEST, WAIT_RESP. Reset enters IDLE. IDLE always moves to REQUEST on the next cycle.
- REQUEST:
  - mem_req_valid = 1 only when the output slot is free (!inst_valid || inst_ready).
  - mem_req_addr = pc_address; the address is also latched as req_pc.
  - Handshake (valid && ready) moves to WAIT_RESP. Otherwise the FSM stays in REQUEST, and the address may change.
- WAIT_RESP, on mem_resp_valid with the drop flag clear:
  - inst_data <= mem_resp_data, inst_pc <= req_pc, inst_valid <= 1.
  - The FSM goes to REQUEST.
- pc_halt = 0 in exactly two cases:
  - (a) cycle of an accepted, non-dropped response;
  - (b) any cycle with flush = 1.
  - Otherwise pc_halt = 1, including in IDLE and during reset.
- inst_valid clears when inst_ready = 1 and no new word is captured in the same cycle. Capture and consume in the same cycle leaves inst_valid = 1 with the new data.
- flush:
  - Clears inst_valid at the next edge.
  - In WAIT_RESP, or in REQUEST with a handshake that same cycle, it sets the drop flag. The next response is then discarded: no capture, pc_halt stays 1. The drop flag clears and the FSM returns to REQUEST.
  - In REQUEST without a handshake, it simply stays in REQUEST; the new pc_address is used next cycle.
- Flush coinciding with a response in WAIT_RESP discards that response and sets no drop flag.
- mem_resp_valid outside WAIT_RESP is ignored.
- At most one request is outstanding.

## Timing
- Reset values: inst_valid 0, inst_data 0, inst_pc 0, mem_req_valid 0, mem_req_addr 0, pc_halt 1, drop flag 0, state IDLE.
- Reset mid-fetch abandons the fetch. A response arriving after reset is ignored, because the FSM is in IDLE or REQUEST.
- The first request is asserted 1 cycle after reset deasserts.
- If the request is accepted in cycle N and the response arrives in N+k (k ≥ 1), inst_valid is high from N+k+1. The PC shows the next address from N+k+1, and the next request can be accepted at N+k+1.
- Back-to-back throughput with k = 1 and the decoder always ready: one instruction every 2 cycles.
- pc_halt is combinational from state, mem_resp_valid, drop and flush. All other outputs are registered, except mem_req_valid/mem_req_addr, which are combinational from state, pc_address and the output-slot status.

## Structure
- Shared package `catcore_fetch_pkg`: state encoding localparams (IDLE = 2'd0, REQUEST = 2'd1, WAIT_RESP = 2'd2), default ADDR_WIDTH/DATA_WIDTH.
- Sub-module `fetch_output_register`: a one-entry valid/ready holding register for inst_data/inst_pc with load, consume and clear inputs.
- The FSM, drop flag and pc_halt logic stay in `instruction_fetch_unit`.

## Test plan
- Reset held 3 cycles, then released: outputs at reset values. mem_req_valid = 1 with mem_req_addr = pc_address = 0x0 on the first cycle after release; pc_halt = 1 throughout.
- Memory ready = 1 with 1-cycle response 0x00A00093 for 0x0: pc_halt = 0 for one cycle. Next cycle inst_valid = 1, inst_data = 0x00A00093, inst_pc = 0x0. The next request goes to 0x4.
- Decoder holds inst_ready = 0 for 5 cycles: no new request is issued, and inst_data is stable. inst_ready = 1 allows a request in the same cycle.
- flush with pc_address → 0x40 while in WAIT_RESP, response 0xDEADBEEF 2 cycles later: the response is discarded, inst_valid = 0, and pc_halt stays 1 on the dropped response. The next request addresses 0x40.
- mem_req_ready held low for 4 cycles: mem_req_valid stays high and the request is accepted on the first ready cycle. A spurious mem_resp_valid in REQUEST changes nothing.
- Reset asserted while in WAIT_RESP, with the response arriving during reset: nothing is captured, the FSM goes to IDLE, and inst_valid = 0.
